// File: rtl/spi_slave_rx_mode3.sv
// SPI mode-3 byte receiver: oversamples CS_N/SCLK/MOSI into In_clk and hands words out over valid/ready.
// Optional partial-word abort reporting on Out_frame_err is compiled in with SPI_RX_FRAME_ERR_EN.
module spi_slave_rx_mode3 #(
  parameter int DATA_W = 8
) (
  input  logic              In_clk,
  input  logic              In_rst,
  input  logic              In_spi_cs_n,
  input  logic              In_spi_sclk,
  input  logic              In_spi_mosi,
  input  logic              In_rx_ready,
  output logic [DATA_W-1:0] Out_rx_data,
  output logic              Out_rx_valid,
  output logic              Out_rx_busy,
  output logic              Out_overrun,
  output logic              Out_frame_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              overrun;

  logic cs_s1, cs_s2;
  logic sclk_s1, sclk_s2, sclk_prev;
  logic mosi_s1, mosi_s2;

  logic              sclk_rise;
  logic [DATA_W-1:0] shift_next;

  assign sclk_rise  = sclk_s2 && !sclk_prev;
  assign shift_next = {shift[DATA_W-2:0], mosi_s2};

  // Handshake: a word moves downstream on any In_clk edge where Out_rx_valid && In_rx_ready;
  // Out_rx_data is frozen while valid is high and valid only falls through such a transfer.
  always_ff @(posedge In_clk) begin
    if (In_rst) begin
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      sclk_s1   <= 1'b1;
      sclk_s2   <= 1'b1;
      sclk_prev <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cs_s1     <= In_spi_cs_n;
      cs_s2     <= cs_s1;
      sclk_s1   <= In_spi_sclk;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      mosi_s1   <= In_spi_mosi;
      mosi_s2   <= mosi_s1;
      overrun   <= 1'b0;

      if (rx_valid && In_rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!cs_s2) begin
            state   <= RECV;
            bit_cnt <= '0;
            shift   <= '0;
          end
        end
        RECV: begin
          // Deselect wins over a coincident SCLK edge; any partial word is dropped.
          if (cs_s2) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            shift <= shift_next;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              if (!rx_valid || In_rx_ready) begin
                rx_data  <= shift_next;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  logic frame_err;

  always_ff @(posedge In_clk) begin
    if (In_rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= (state == RECV) && cs_s2 && (bit_cnt != '0);
    end
  end

  assign Out_frame_err = frame_err;
`else
  assign Out_frame_err = 1'b0;
`endif

  assign Out_rx_data  = rx_data;
  assign Out_rx_valid = rx_valid;
  assign Out_rx_busy  = (state == RECV);
  assign Out_overrun  = overrun;

endmodule

// File: tb/tb_spi_slave_rx_mode3.sv
// Directed bench for spi_slave_rx_mode3: a mode-3 master model drives frames, a negedge monitor
// scores every handshake transfer against an expected queue and counts side-band pulses.
module tb_spi_slave_rx_mode3;

  localparam int DATA_W = 8;
`ifdef SPI_RX_FRAME_ERR_EN
  localparam int EXP_FE = 1;
`else
  localparam int EXP_FE = 0;
`endif

  logic              clk;
  logic              rst;
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_busy;
  logic              overrun;
  logic              frame_err;

  int n_checks = 0;
  int n_errors = 0;

  int n_xfer, n_spur, n_ovr, n_fe, n_valid_cyc, n_busy_cyc;
  logic [DATA_W-1:0] exp_q[$];

  spi_slave_rx_mode3 #(.DATA_W(DATA_W)) dut (
    .In_clk        (clk),
    .In_rst        (rst),
    .In_spi_cs_n   (spi_cs_n),
    .In_spi_sclk   (spi_sclk),
    .In_spi_mosi   (spi_mosi),
    .In_rx_ready   (rx_ready),
    .Out_rx_data   (rx_data),
    .Out_rx_valid  (rx_valid),
    .Out_rx_busy   (rx_busy),
    .Out_overrun   (overrun),
    .Out_frame_err (frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) n_valid_cyc++;
      if (rx_busy) n_busy_cyc++;
      if (overrun) n_ovr++;
      if (frame_err) n_fe++;
      if (rx_valid && rx_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_spur++;
        end else begin
          check("rx_word", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    n_xfer = 0; n_spur = 0; n_ovr = 0; n_fe = 0; n_valid_cyc = 0; n_busy_cyc = 0;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic spi_bits(input logic [DATA_W-1:0] data, input int nbits);
    for (int i = DATA_W - 1; i >= DATA_W - nbits; i--) begin
      spi_sclk = 1'b0;
      spi_mosi = data[i];
      tick(4);
      spi_sclk = 1'b1;
      tick(4);
    end
  endtask

  task automatic check_pulses(input string tag, input int xfer, input int ovr, input int fe);
    check({tag, "_xfer"}, 32'(n_xfer), 32'(xfer));
    check({tag, "_spur"}, 32'(n_spur), 32'd0);
    check({tag, "_ovr"},  32'(n_ovr),  32'(ovr));
    check({tag, "_fe"},   32'(n_fe),   32'(fe));
  endtask

  initial begin
    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b1; spi_mosi = 1'b0; rx_ready = 1'b0;
    clear_counts();
    tick(4);
    @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data",  32'(rx_data),  32'd0);
    check("rst_busy",  32'(rx_busy),  32'd0);
    check("rst_ovr",   32'(overrun),  32'd0);
    check("rst_fe",    32'(frame_err), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(4);

    // single word
    rx_ready = 1'b1;
    clear_counts();
    exp_q.push_back(8'hA5);
    cs_low();
    @(negedge clk);
    check("t1_busy_in", 32'(rx_busy), 32'd1);
    tick(0);
    spi_bits(8'hA5, 8);
    cs_high();
    @(negedge clk);
    check("t1_busy_out", 32'(rx_busy), 32'd0);
    check("t1_valid_cyc", 32'(n_valid_cyc), 32'd1);
    check_pulses("t1", 1, 0, 0);

    // two words in one frame
    clear_counts();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    tick(1);
    cs_low();
    spi_bits(8'h3C, 8);
    @(negedge clk);
    check("t2_busy_mid", 32'(rx_busy), 32'd1);
    tick(0);
    spi_bits(8'hC3, 8);
    cs_high();
    check_pulses("t2", 2, 0, 0);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // backpressure
    rx_ready = 1'b0;
    clear_counts();
    exp_q.push_back(8'h11);
    cs_low();
    spi_bits(8'h11, 8);
    cs_high();
    cs_low();
    spi_bits(8'h22, 8);
    cs_high();
    @(negedge clk);
    check("t3_valid_held", 32'(rx_valid), 32'd1);
    check("t3_data_held",  32'(rx_data),  32'h11);
    check("t3_ovr", 32'(n_ovr), 32'd1);
    tick(1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    @(negedge clk);
    check("t3_valid_drop", 32'(rx_valid), 32'd0);
    tick(20);
    check_pulses("t3", 1, 1, 0);

    // abort after 5 bits, then a clean frame
    rx_ready = 1'b1;
    clear_counts();
    cs_low();
    spi_bits(8'hFF, 5);
    cs_high();
    @(negedge clk);
    check("t4_busy_out", 32'(rx_busy), 32'd0);
    check("t4_valid", 32'(n_valid_cyc), 32'd0);
    check_pulses("t4a", 0, 0, EXP_FE);
    clear_counts();
    exp_q.push_back(8'hF0);
    tick(1);
    cs_low();
    spi_bits(8'hF0, 8);
    cs_high();
    check_pulses("t4b", 1, 0, 0);

    // reset mid-word
    clear_counts();
    cs_low();
    spi_bits(8'h55, 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_valid", 32'(rx_valid), 32'd0);
    check("t5_data",  32'(rx_data),  32'd0);
    check("t5_busy",  32'(rx_busy),  32'd0);
    check("t5_ovr",   32'(overrun),  32'd0);
    check("t5_fe",    32'(frame_err), 32'd0);
    tick(0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
    clear_counts();
    exp_q.push_back(8'h81);
    cs_low();
    spi_bits(8'h81, 8);
    cs_high();
    check_pulses("t5", 1, 0, 0);

    // SCLK toggling while deselected
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      spi_sclk = ~spi_sclk;
      spi_mosi = i[0];
      tick(4);
    end
    tick(8);
    check("t6_busy_cyc",  32'(n_busy_cyc),  32'd0);
    check("t6_valid_cyc", 32'(n_valid_cyc), 32'd0);
    check_pulses("t6", 0, 0, 0);
    check("end_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_mode3.md
# spi_slave_rx_mode3

SPI mode-3 (CPOL=1, CPHA=1) byte receiver that consumes the chip-select, serial clock and data lines produced by the team's SPI master transmitter. Received bytes are delivered to the local system clock domain through a valid/ready handshake. The SPI inputs are asynchronous to `In_clk`, so they are oversampled and edge-detected. The block sits at the far end of the SPI link, directly downstream of the mode-3 master TX.

## Interface
- `DATA_W`, default 8: bits per SPI word, shifted MSB first.

- `In_clk`  in  1  system clock; the only clock in the block.
- `In_rst`  in  1  reset, synchronous and active-high.
- `In_spi_cs_n`  in  1  chip select, active-low, asynchronous to `In_clk`.
- `In_spi_sclk`  in  1  SPI clock, idle high, asynchronous to `In_clk`.
- `In_spi_mosi`  in  1  serial data; changes on the SCLK falling edge and is sampled on the rising edge.
- `In_rx_ready`  in  1  downstream accepts `Out_rx_data` this cycle.
- `Out_rx_data`  out  DATA_W  received word, held stable while `Out_rx_valid` is high.
- `Out_rx_valid`  out  1  holding register full.
- `Out_rx_busy`  out  1  high while in state RECV.
- `Out_overrun`  out  1  one-cycle pulse: a word completed while the holding register was full and not being accepted.
- `Out_frame_err`  out  1  one-cycle pulse: CS_N deasserted mid-word (requires the `SPI_RX_FRAME_ERR_EN` macro).

## Operation
- **Input synchronisers.** Each of CS_N, SCLK and MOSI passes through a 2-flop synchroniser.
  - Reset values: cs_n=1, sclk=1, mosi=0.
  - A third register holds the previous synchronised SCLK.
  - Rising edge is detected as sclk_s2=1 and sclk_prev=0.
- **State IDLE.** When synchronised cs_n=0: go to RECV and clear bit_cnt and the shift register.
- **State RECV, rising edge.**
  - Shift: shift = {shift[DATA_W-2:0], mosi_s2}.
  - Count: bit_cnt++.
- **State RECV, word completion.** On the rising edge with bit_cnt==DATA_W-1:
  - If the holding register is empty, or `In_rx_ready` is high this cycle, load the assembled word into the holding register and set valid.
  - Otherwise drop the word, keep the holding register unchanged and pulse `Out_overrun`.
  - bit_cnt wraps to 0 and the block stays in RECV, so multi-word frames under one CS_N are supported.
- **State RECV, CS_N deasserted.** When synchronised cs_n=1: go to IDLE.
  - If bit_cnt!=0, the partial word is discarded.
  - `Out_frame_err` pulses for one cycle (macro-dependent, see Configuration).
- **CS_N versus SCLK priority.** A CS_N deassertion and an SCLK rising edge seen in the same cycle: CS_N wins and the edge is ignored.
- **SCLK while deselected.** SCLK edges while synchronised cs_n=1 are ignored.
- **Output handshake.**
  - A transfer occurs when valid && ready.
  - Valid clears on transfer unless a new word loads in the same cycle; in that case valid stays 1 and the data updates.
  - Valid is never dropped without a transfer, except by reset.
- **Reset.** `In_rst` at any time, including mid-word:
  - State returns to IDLE; bit_cnt, shift and holding registers clear.
  - All outputs go to 0: `Out_rx_data`, `Out_rx_valid`, `Out_rx_busy`, `Out_overrun`, `Out_frame_err`.

## Timing
- **Latency.** `Out_rx_valid` rises on the 3rd `In_clk` edge after the edge that first samples the final SCLK rising edge at the pin:
  - edge 1 and edge 2: synchroniser stages;
  - edge 3: registered load.
- **Other signals, same latency.**
  - `Out_overrun` pulses in that same cycle.
  - `Out_rx_busy` rises 3 cycles after CS_N falls at the pin.
  - `Out_rx_busy` falls, and `Out_frame_err` pulses, 3 cycles after CS_N rises at the pin.
- **SCLK rate limit.** SCLK high and low phases must each be at least 3 `In_clk` periods. The master at REF_CLK/SPI_SCLK=1000 meets this trivially.
- **Setup to first edge.** CS_N falling must precede the first SCLK rising edge by at least 3 `In_clk` periods.
- **Throughput.** One word per DATA_W SCLK periods. A downstream that holds ready high never causes overrun.

## Configuration
- Macro `SPI_RX_FRAME_ERR_EN`.
- **Defined:** partial-word detection is compiled in, and `Out_frame_err` pulses for one cycle when CS_N rises with bit_cnt!=0.
- **Not defined:**
  - the detection logic is absent and `Out_frame_err` is tied to 0;
  - the partial word is still discarded silently;
  - all other behaviour is identical.

## Test plan
- **Single word.** Master model (SCLK half-period 4 clks) sends 0xA5, ready=1 → exactly one valid cycle with data 0xA5; busy high for the CS_N window; no overrun or frame_err.
- **Two-word frame.** 0x3C then 0xC3 under one CS_N low, ready=1 → two valid pulses carrying 0x3C then 0xC3; busy stays high throughout; no frame_err.
- **Backpressure.** ready=0; send 0x11, then 0x22 → valid held with 0x11; one overrun pulse when 0x22 completes. Then raise ready for one cycle → 0x11 transferred, valid drops, 0x22 never appears.
- **Abort.** CS_N rises after 5 bits of 0xFF → frame_err pulses once with the macro and stays 0 without it; no valid. The next frame 0xF0 is received correctly.
- **Reset mid-word.** Assert `In_rst` after 3 bits → all outputs 0 on the next clk. A fresh frame 0x81 is then received as 0x81.
- **SCLK while deselected.** SCLK toggled 16 times with CS_N high → busy, valid, overrun and frame_err all remain 0.
